// File: rtl/apb_master_bridge.sv
// APB requester: turns single-beat valid/ready commands into APB SETUP/ACCESS transfers
// and returns one-cycle responses, aborting via a wait-state watchdog if the slave stalls.
module apb_master_bridge #(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_WRITE,
  input  logic [ADDR_WD-1:0] CMD_ADDR,
  input  logic [DATA_WD-1:0] CMD_WDATA,
  input  logic [3:0]         CMD_STRB,
  output logic               RSP_VALID,
  output logic [DATA_WD-1:0] RSP_RDATA,
  output logic [1:0]         RSP_ERR,
  output logic               RSP_TIMEOUT,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_WD-1:0] PADDR,
  output logic [DATA_WD-1:0] PWDATA,
  output logic [3:0]         PSTRB,
  input  logic               PREADY,
  input  logic [DATA_WD-1:0] PRDATA,
  input  logic [1:0]         PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  localparam logic [7:0] TO_LIM = TIMEOUT[7:0];
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_t               r_state, w_state_next;
  logic                 r_psel, w_psel_next;
  logic                 r_penable, w_penable_next;
  logic                 r_pwrite, w_pwrite_next;
  logic [ADDR_WD-1:0]   r_paddr, w_paddr_next;
  logic [DATA_WD-1:0]   r_pwdata, w_pwdata_next;
  logic [3:0]           r_pstrb, w_pstrb_next;
  logic                 r_rsp_valid, w_rsp_valid_next;
  logic [DATA_WD-1:0]   r_rsp_rdata, w_rsp_rdata_next;
  logic [1:0]           r_rsp_err, w_rsp_err_next;
  logic                 r_rsp_timeout, w_rsp_timeout_next;
  logic [7:0]           r_wd, w_wd_next;
  logic [7:0]           w_wd_inc;
  logic                 w_accept;

  assign CMD_READY = PRESETn & ((r_state == S_IDLE) | ((r_state == S_ACCESS) & PREADY));
  assign w_accept  = CMD_VALID & CMD_READY;
  assign w_wd_inc  = (r_wd == 8'hFF) ? r_wd : r_wd + 8'd1;

  always_comb begin
    w_state_next       = r_state;
    w_psel_next        = r_psel;
    w_penable_next     = r_penable;
    w_pwrite_next      = r_pwrite;
    w_paddr_next       = r_paddr;
    w_pwdata_next      = r_pwdata;
    w_pstrb_next       = r_pstrb;
    w_rsp_valid_next   = 1'b0;
    w_rsp_rdata_next   = r_rsp_rdata;
    w_rsp_err_next     = r_rsp_err;
    w_rsp_timeout_next = 1'b0;
    w_wd_next          = r_wd;

    // A freshly accepted command is loaded the same way from IDLE or at ACCESS completion.
    if (w_accept) begin
      w_pwrite_next  = CMD_WRITE;
      w_paddr_next   = CMD_ADDR;
      w_pwdata_next  = CMD_WDATA;
      w_pstrb_next   = CMD_WRITE ? CMD_STRB : 4'b0000;
      w_psel_next    = 1'b1;
      w_penable_next = 1'b0;
      w_state_next   = S_SETUP;
    end

    case (r_state)
      S_IDLE: ;
      S_SETUP: begin
        w_penable_next = 1'b1;
        w_wd_next      = 8'd0;
        w_state_next   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = PSLVERR;
          w_rsp_rdata_next = r_pwrite ? '0 : PRDATA;
          if (!w_accept) begin
            w_psel_next    = 1'b0;
            w_penable_next = 1'b0;
            w_state_next   = S_IDLE;
          end
        end else begin
          w_wd_next = w_wd_inc;
          if (TO_EN && (w_wd_inc >= TO_LIM)) begin
            w_rsp_valid_next   = 1'b1;
            w_rsp_timeout_next = 1'b1;
            w_rsp_err_next     = 2'b00;
            w_rsp_rdata_next   = '0;
            w_psel_next        = 1'b0;
            w_penable_next     = 1'b0;
            w_state_next       = S_IDLE;
          end
        end
      end
      default: begin
        w_psel_next    = 1'b0;
        w_penable_next = 1'b0;
        w_state_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= 4'b0000;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 2'b00;
      r_rsp_timeout <= 1'b0;
      r_wd          <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_psel        <= w_psel_next;
      r_penable     <= w_penable_next;
      r_pwrite      <= w_pwrite_next;
      r_paddr       <= w_paddr_next;
      r_pwdata      <= w_pwdata_next;
      r_pstrb       <= w_pstrb_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_rdata   <= w_rsp_rdata_next;
      r_rsp_err     <= w_rsp_err_next;
      r_rsp_timeout <= w_rsp_timeout_next;
      r_wd          <= w_wd_next;
    end
  end

  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_RDATA   = r_rsp_rdata;
  assign RSP_ERR     = r_rsp_err;
  assign RSP_TIMEOUT = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: hand-computed expectations checked with immediate assertions.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [15:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic [3:0]  CMD_STRB;
  logic        RSP_VALID, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_ERR;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic [1:0]  PSLVERR;

  int n_pass  = 0;
  int n_total = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.DATA_WD(32), .ADDR_WD(16), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESETn = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0;
    CMD_WDATA = '0; CMD_STRB = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = '0;
    tick; tick;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_paddr", PADDR, 0);
    PRESETn = 1'b1;
    #1 chk("idle_cmd_ready", CMD_READY, 1);

    // 1: zero-wait write
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 12; CMD_WDATA = 152; CMD_STRB = 4'hF;
    tick; CMD_VALID = 0; PREADY = 1;
    $display("t1 write @12 accepted");
    chk("t1_setup_psel", PSEL, 1);
    chk("t1_setup_penable", PENABLE, 0);
    chk("t1_paddr", PADDR, 12);
    chk("t1_pwdata", PWDATA, 152);
    chk("t1_pstrb", PSTRB, 4'hF);
    chk("t1_pwrite", PWRITE, 1);
    tick;
    chk("t1_access_penable", PENABLE, 1);
    chk("t1_access_rsp", RSP_VALID, 0);
    tick;
    chk("t1_rsp_valid", RSP_VALID, 1);
    chk("t1_rsp_err", RSP_ERR, 0);
    chk("t1_rsp_rdata", RSP_RDATA, 0);
    chk("t1_psel_drop", PSEL, 0);
    PREADY = 0;
    tick;
    chk("t1_rsp_pulse", RSP_VALID, 0);

    // 2: read with 3 wait states
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 34; CMD_STRB = 4'hF;
    tick; CMD_VALID = 0;
    $display("t2 read @34 accepted");
    chk("t2_pstrb", PSTRB, 0);
    chk("t2_pwrite", PWRITE, 0);
    chk("t2_paddr_setup", PADDR, 34);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("t2_paddr_wait", PADDR, 34);
      chk("t2_penable_wait", PENABLE, 1);
      chk("t2_no_rsp", RSP_VALID, 0);
      chk("t2_ready_wait", CMD_READY, 0);
      tick;
    end
    PREADY = 1; PRDATA = 150;
    #1 chk("t2_ready_done", CMD_READY, 1);
    tick;
    chk("t2_rsp_valid", RSP_VALID, 1);
    chk("t2_rsp_rdata", RSP_RDATA, 150);
    chk("t2_rsp_err", RSP_ERR, 0);
    PREADY = 0; PRDATA = 0;
    tick;
    chk("t2_rsp_pulse", RSP_VALID, 0);

    // 3: write completing with slave error
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 5; CMD_WDATA = 32'h77; CMD_STRB = 4'h3;
    PREADY = 1; PSLVERR = 2'b01; PRDATA = 32'hDEAD;
    tick; CMD_VALID = 0;
    $display("t3 write @5 accepted");
    tick; tick;
    chk("t3_rsp_valid", RSP_VALID, 1);
    chk("t3_rsp_err", RSP_ERR, 2'b01);
    chk("t3_rsp_timeout", RSP_TIMEOUT, 0);
    chk("t3_rsp_rdata", RSP_RDATA, 0);
    PREADY = 0; PSLVERR = 0; PRDATA = 0;
    tick;

    // 4: watchdog abort after 8 ACCESS cycles
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 7;
    tick; CMD_VALID = 0; PSLVERR = 2'b11; PRDATA = 32'h55;
    $display("t4 read @7 accepted, slave stalls");
    tick;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("t4_no_rsp", RSP_VALID, 0);
      chk("t4_psel_held", PSEL, 1);
    end
    tick;
    chk("t4_rsp_valid", RSP_VALID, 1);
    chk("t4_rsp_timeout", RSP_TIMEOUT, 1);
    chk("t4_rsp_err", RSP_ERR, 0);
    chk("t4_rsp_rdata", RSP_RDATA, 0);
    chk("t4_psel", PSEL, 0);
    chk("t4_penable", PENABLE, 0);
    chk("t4_cmd_ready", CMD_READY, 1);
    PSLVERR = 0; PRDATA = 0;
    tick;
    chk("t4_rsp_pulse", RSP_VALID, 0);

    // 5: back-to-back writes @1,@2,@3
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 1; CMD_WDATA = 1; CMD_STRB = 4'hF; PREADY = 1;
    tick;
    CMD_ADDR = 2; CMD_WDATA = 2;
    for (int i = 1; i <= 6; i++) begin
      tick;
      $display("t5 cycle %0d rsp_valid=%0d psel=%0d paddr=%0d", i, RSP_VALID, PSEL, PADDR);
      chk("t5_rsp_valid", RSP_VALID, (i % 2 == 0) ? 1 : 0);
      chk("t5_psel", PSEL, (i < 6) ? 1 : 0);
      chk("t5_penable", PENABLE, (i % 2 == 1) ? 1 : 0);
      if (i < 6) chk("t5_paddr", PADDR, 64'(i / 2 + 1));
      if (i == 2) begin CMD_ADDR = 3; CMD_WDATA = 3; end
      if (i == 4) CMD_VALID = 0;
    end
    PREADY = 0;
    tick;

    // 6: reset during 2nd ACCESS wait cycle
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 9;
    tick; CMD_VALID = 0;
    $display("t6 read @9 accepted, reset mid-transfer");
    tick; tick;
    PRESETn = 0;
    #1;
    chk("t6_psel", PSEL, 0);
    chk("t6_penable", PENABLE, 0);
    chk("t6_paddr", PADDR, 0);
    chk("t6_cmd_ready", CMD_READY, 0);
    chk("t6_rsp_valid", RSP_VALID, 0);
    PREADY = 1;
    tick;
    chk("t6_rsp_in_rst", RSP_VALID, 0);
    PREADY = 0;
    PRESETn = 1;
    #1 chk("t6_idle_ready", CMD_READY, 1);
    tick;
    chk("t6_no_late_rsp", RSP_VALID, 0);
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 10; CMD_WDATA = 32'hA5; CMD_STRB = 4'hF;
    tick; CMD_VALID = 0; PREADY = 1;
    chk("t6_new_paddr", PADDR, 10);
    tick; tick;
    chk("t6_new_rsp", RSP_VALID, 1);
    chk("t6_new_err", RSP_ERR, 0);
    PREADY = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
